// File: rtl/axil_reg_if_wr.sv
// AXI4-lite write slave that turns each AW/W pair into one register-port write.
// One transaction in flight; OKAY on register ack, SLVERR when the ack never comes.
module axil_reg_if_wr #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_ack
);

  localparam int unsigned LSB_BITS  = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam int unsigned CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((64'd1 << LSB_BITS) - 64'd1);
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    en_q, en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    aw_cap_q, aw_cap_d;
  logic                    w_cap_q, w_cap_d;
  logic                    aw_hs_c, w_hs_c;
  logic                    unused_prot_c;

  // Protection bits carry no meaning for a plain register port.
  assign unused_prot_c = ^s_axil_awprot;

  // Ready is only ever high while collecting, so these are the accepted beats.
  assign aw_hs_c = s_axil_awvalid && awready_q;
  assign w_hs_c  = s_axil_wvalid && wready_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      en_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      cnt_q     <= '0;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      cnt_q     <= cnt_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    en_d      = en_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    aw_cap_d  = aw_cap_q;
    w_cap_d   = w_cap_q;

    case (state_q)
      ST_IDLE: begin
        aw_cap_d = aw_cap_q | aw_hs_c;
        w_cap_d  = w_cap_q | w_hs_c;
        if (aw_hs_c) addr_d = s_axil_awaddr & ADDR_MASK;
        if (w_hs_c) begin
          data_d = s_axil_wdata;
          strb_d = s_axil_wstrb;
        end
        awready_d = !aw_cap_d;
        wready_d  = !w_cap_d;
        if (aw_cap_d && w_cap_d) begin
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (strb_d != '0) begin
            state_d = ST_WRITE;
            en_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            // Nothing to write: answer straight away.
            state_d  = ST_RESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
          end
        end
      end
      ST_WRITE: begin
        if (reg_wr_ack) begin
          state_d  = ST_RESP;
          en_d     = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = RESP_OKAY;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d  = ST_RESP;
          en_d     = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = RESP_SLVERR;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (s_axil_bready) begin
          state_d   = ST_IDLE;
          bvalid_d  = 1'b0;
          aw_cap_d  = 1'b0;
          w_cap_d   = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign reg_wr_en      = en_q;
  assign reg_wr_addr    = addr_q;
  assign reg_wr_data    = data_q;
  assign reg_wr_strb    = strb_q;

endmodule

// File: tb/tb_axil_reg_if_wr.sv
// Bench for axil_reg_if_wr: directed scenarios plus random traffic, every
// output compared each cycle against a transaction-level model.
module tb_axil_reg_if_wr;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_en;
  logic        wr_ack = 1'b0;

  int tests = 0;
  int fails = 0;

  axil_reg_if_wr #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
    .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .reg_wr_strb(wr_strb),
    .reg_wr_en(wr_en), .reg_wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 = collecting AW/W, 1 = register write in progress, 2 = response pending
  int          phase = 0;
  bit          have_aw, have_w;
  int          en_cycles;
  bit          m_awready, m_wready, m_bvalid, m_en;
  logic [1:0]  m_bresp;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_strb;
  bit          chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0; have_aw = 0; have_w = 0; en_cycles = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_en = 0; m_bresp = 2'b00;
      m_addr = '0; m_data = '0; m_strb = '0;
      chk_on = 1'b1;
    end else begin
      case (phase)
        0: begin
          if (awvalid && m_awready) begin
            have_aw = 1; m_addr = {awaddr[31:2], 2'b00};
          end
          if (wvalid && m_wready) begin
            have_w = 1; m_data = wdata; m_strb = wstrb;
          end
          if (have_aw && have_w) begin
            have_aw = 0; have_w = 0; m_awready = 0; m_wready = 0;
            if (m_strb != 4'h0) begin
              phase = 1; m_en = 1; en_cycles = 0;
            end else begin
              phase = 2; m_bvalid = 1; m_bresp = 2'b00;
            end
          end else begin
            m_awready = !have_aw; m_wready = !have_w;
          end
        end
        1: begin
          en_cycles++;
          if (wr_ack) begin
            phase = 2; m_en = 0; m_bvalid = 1; m_bresp = 2'b00;
          end else if (en_cycles == TIMEOUT) begin
            phase = 2; m_en = 0; m_bvalid = 1; m_bresp = 2'b10;
          end
        end
        default: begin
          if (bready) begin
            phase = 0; m_bvalid = 0; m_awready = 1; m_wready = 1;
          end
        end
      endcase
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("awready", 64'(awready), 64'(m_awready));
      chk("wready",  64'(wready),  64'(m_wready));
      chk("bvalid",  64'(bvalid),  64'(m_bvalid));
      chk("bresp",   64'(bresp),   64'(m_bresp));
      chk("wr_en",   64'(wr_en),   64'(m_en));
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wr_data), 64'(m_data));
      chk("wr_strb", 64'(wr_strb), 64'(m_strb));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
    cyc();
    awvalid = 0; wvalid = 0;
  endtask

  task automatic take_resp();
    bready = 1;
    cyc();
    bready = 0;
  endtask

  initial begin
    int n;
    int resp_count;
    bit aw_fire, w_fire, b_fire;

    // Reset state
    repeat (3) cyc();
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready",  64'(wready),  64'd0);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_en",      64'(wr_en),   64'd0);
    chk("rst_addr",    64'(wr_addr), 64'd0);
    rst = 0;
    cyc();
    chk("ready_after_rst", 64'({awready, wready}), 64'h3);

    // AW and W together, ack two cycles after enable
    send_both(32'h0000_1007, 32'hDEAD_BEEF, 4'hF);
    chk("t1_addr", 64'(wr_addr), 64'h0000_1004);
    chk("t1_data", 64'(wr_data), 64'hDEAD_BEEF);
    n = 0;
    while (wr_en && n < 50) begin
      n++;
      if (n == 3) wr_ack = 1;
      cyc();
    end
    wr_ack = 0;
    chk("t1_en_cycles", 64'(n), 64'd3);
    chk("t1_bvalid", 64'(bvalid), 64'd1);
    chk("t1_bresp",  64'(bresp),  64'd0);
    take_resp();

    // W five cycles ahead of AW
    wvalid = 1; wdata = 32'h1234_5678; wstrb = 4'h3;
    cyc();
    wvalid = 0;
    chk("t2_wready_drop", 64'({awready, wready}), 64'h2);
    repeat (4) cyc();
    awvalid = 1; awaddr = 32'h20;
    cyc();
    awvalid = 0;
    chk("t2_en",   64'(wr_en),   64'd1);
    chk("t2_strb", 64'(wr_strb), 64'h3);
    chk("t2_addr", 64'(wr_addr), 64'h20);
    wr_ack = 1;
    cyc();
    wr_ack = 0;
    chk("t2_bresp", 64'({bvalid, bresp}), 64'h4);
    take_resp();

    // Timeout, then a 10-cycle bready stall on the SLVERR response
    send_both(32'h44, 32'hA5A5_0001, 4'h1);
    n = 0;
    while (wr_en && n < 50) begin n++; cyc(); end
    chk("t3_en_cycles", 64'(n), 64'd16);
    chk("t3_slverr", 64'({bvalid, bresp}), 64'h6);
    for (int i = 0; i < 10; i++) begin
      chk("t5_stall", 64'({bvalid, bresp, awready, wready}), 64'h18);
      cyc();
    end
    bready = 1;
    cyc();
    bready = 0;
    chk("t5_release", 64'({bvalid, awready, wready}), 64'h3);

    // Ack on the final cycle still gives OKAY
    send_both(32'h48, 32'hA5A5_0002, 4'hC);
    n = 0;
    while (wr_en && n < 50) begin
      n++;
      if (n == 16) wr_ack = 1;
      cyc();
    end
    wr_ack = 0;
    chk("t3_ack_last_cycles", 64'(n), 64'd16);
    chk("t3_ack_last_okay", 64'({bvalid, bresp}), 64'h4);
    take_resp();

    // Zero strobes: no register write, immediate OKAY
    wr_ack = 1;
    send_both(32'h50, 32'hFFFF_FFFF, 4'h0);
    wr_ack = 0;
    chk("t4_no_en", 64'(wr_en), 64'd0);
    chk("t4_resp",  64'({bvalid, bresp}), 64'h4);
    take_resp();

    // Reset on the second enable cycle aborts the write
    send_both(32'h60, 32'h0BAD_F00D, 4'hF);
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("t6_abort", 64'({wr_en, bvalid, awready, wready}), 64'h0);
    chk("t6_abort_regs", 64'({wr_addr, wr_data}), 64'h0);
    cyc();
    send_both(32'h64, 32'h0000_0001, 4'h1);
    wr_ack = 1;
    cyc();
    wr_ack = 0;
    chk("t6_fresh_okay", 64'({bvalid, bresp}), 64'h4);
    take_resp();

    // Random traffic with occasional resets
    resp_count = 0;
    for (int c = 0; c < 4000; c++) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      b_fire  = bvalid && bready && !rst;
      cyc();
      if (b_fire) resp_count++;
      if (aw_fire || rst) awvalid = 0;
      if (w_fire || rst) wvalid = 0;
      rst = ($urandom_range(0, 599) == 0);
      if (!awvalid && $urandom_range(0, 3) == 0) begin
        awvalid = 1; awaddr = $urandom; awprot = 3'($urandom);
      end
      if (!wvalid && $urandom_range(0, 3) == 0) begin
        wvalid = 1; wdata = $urandom;
        wstrb = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      end
      wr_ack = ($urandom_range(0, 5) == 0);
      bready = ($urandom_range(0, 2) == 0);
    end
    chk("rand_progress", 64'(resp_count > 50), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_reg_if_wr.md
Name: axil_reg_if_wr

Overview:
- AXI4-lite write slave that terminates the write channel and drives a simple single-port register write interface.
- Sits directly downstream of the AXI-lite write man-in-the-middle / register stage and consumes its m_axil_aw/w/b channels.
- Accepts AW and W in either order and issues one register write per transaction.
- Returns OKAY on register acknowledge and SLVERR on timeout.
- Only one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, address bus width in bits.
- DATA_WIDTH, 32, data bus width in bits.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
- TIMEOUT, 16, maximum number of cycles reg_wr_en is held without reg_wr_ack. 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- s_axil_awaddr  input  ADDR_WIDTH  write address.
- s_axil_awprot  input  3  protection; accepted and ignored.
- s_axil_awvalid  input  1  address valid.
- s_axil_awready  output  1  address ready, registered.
- s_axil_wdata  input  DATA_WIDTH  write data.
- s_axil_wstrb  input  STRB_WIDTH  byte strobes.
- s_axil_wvalid  input  1  data valid.
- s_axil_wready  output  1  data ready, registered.
- s_axil_bresp  output  2  response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axil_bvalid  output  1  response valid.
- s_axil_bready  input  1  response ready.
- reg_wr_addr  output  ADDR_WIDTH  awaddr with the low log2(STRB_WIDTH) bits forced to 0.
- reg_wr_data  output  DATA_WIDTH  captured wdata.
- reg_wr_strb  output  STRB_WIDTH  captured wstrb.
- reg_wr_en  output  1  write request; held high until ack or timeout.
- reg_wr_ack  input  1  write acknowledge; sampled only while reg_wr_en=1.

Behaviour:
- Reset values: awready=0, wready=0, bvalid=0, bresp=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, reg_wr_strb=0, timeout counter=0, state=IDLE.
- All outputs are registered; there is no combinational input-to-output path.
- State IDLE (collecting):
  - awready_next = !aw_captured; wready_next = !w_captured. Both ready rise the cycle after rst deasserts.
  - An AW handshake latches addr and sets aw_captured; awready drops next cycle. W is handled the same way.
  - AW and W may complete in the same cycle, or in either order with any gap.
  - When both are captured (including the cycle in which the second one handshakes):
    - if wstrb != 0: go to WRITE; reg_wr_en=1 on the next cycle.
    - if wstrb == 0: no register write; go to RESP with bresp=OKAY and bvalid=1 on the next cycle.
- State WRITE:
  - reg_wr_en=1; addr/data/strb are stable.
  - The counter starts at 0 on the first en cycle and increments on each en cycle without ack.
  - reg_wr_en && reg_wr_ack: reg_wr_en=0 next cycle; bvalid=1, bresp=OKAY next cycle; go to RESP.
  - If TIMEOUT>0, counter==TIMEOUT-1 and no ack: reg_wr_en=0 next cycle; bvalid=1, bresp=SLVERR; go to RESP. reg_wr_en is therefore high for exactly TIMEOUT cycles.
  - Ack on the final cycle wins and gives OKAY.
  - Counter width is clog2(TIMEOUT+1), minimum 1.
- State RESP:
  - bvalid stays high and bresp stays stable until bready.
  - bvalid && bready: bvalid=0, aw/w_captured cleared, awready=wready=1 next cycle; go to IDLE.
  - awready and wready are held 0 throughout WRITE and RESP.
- reg_wr_ack while reg_wr_en=0 is ignored.
- Latency: second capture at cycle N → reg_wr_en at N+1. Ack at M → bvalid at M+1. bready at K → awready/wready at K+1.
- rst at any point (mid-WRITE or mid-RESP) aborts the transaction. All outputs return to reset values on the next cycle and no response is issued for the aborted write.

Test Plan:
- AW and W in the same cycle (addr 0x0000_1007, data 0xDEADBEEF, strb 4'hF), ack 2 cycles after en: reg_wr_addr=0x0000_1004, en high 3 cycles, bresp=00, bvalid 1 cycle after ack.
- W 5 cycles before AW (addr 0x20, data 0x12345678, strb 4'h3): wready drops after W; en rises the cycle after the AW handshake with strb=4'h3; OKAY response.
- No ack with TIMEOUT=16: en high exactly 16 cycles, then bvalid=1 and bresp=2'b10. Ack on the 16th cycle instead gives bresp=00.
- wstrb=4'h0 write: reg_wr_en never asserts; bvalid the cycle after capture with bresp=00.
- bready held low 10 cycles after bvalid: bvalid/bresp stable; awready=wready=0 throughout; both rise 1 cycle after bready.
- rst asserted on the 2nd cycle of en: next cycle en=0, bvalid=0, all outputs at reset values. A following fresh write completes normally with OKAY.
